// File: rtl/int_divider.sv
// Multi-cycle integer divider for the RV M-extension divide group (DIV/DIVU/REM/REMU).
// Restoring division, one quotient bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module int_divider #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            Start,
    input  logic            Kill,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] Rs1,
    input  logic [XLEN-1:0] Rs2,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_C = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_C  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic            rem_sel_r, dvd_sgn_r, dvs_sgn_r;
    logic [XLEN-1:0] quo_r, dvs_r, rem_r, result_r;
    logic            busy_r, done_r;

    logic            signed_op_s, rs1_neg_s, rs2_neg_s;
    logic [XLEN-1:0] rs1_mag_s, rs2_mag_s;
    logic            div_zero_s, ovf_s, fast_s, accept_s, last_s, q_bit_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] rem_next_s, quo_next_s, quo_fix_s, rem_fix_s;
    logic [XLEN-1:0] calc_result_s, fast_result_s;

    // Unsigned ops treat both operands as non-negative.
    assign signed_op_s = ~Op[0];
    assign rs1_neg_s   = signed_op_s & Rs1[XLEN-1];
    assign rs2_neg_s   = signed_op_s & Rs2[XLEN-1];
    assign rs1_mag_s   = rs1_neg_s ? (ZERO_C - Rs1) : Rs1;
    assign rs2_mag_s   = rs2_neg_s ? (ZERO_C - Rs2) : Rs2;

    assign div_zero_s  = (Rs2 == ZERO_C);
    assign ovf_s       = signed_op_s & (Rs1 == MIN_C) & (Rs2 == ONES_C);
    assign fast_s      = div_zero_s | ovf_s;
    assign accept_s    = (state_r == IDLE) & Start & ~Kill;
    assign last_s      = (cnt_r == CW'(XLEN - 1));

    assign fast_result_s = div_zero_s ? (Op[1] ? Rs1 : ONES_C)
                                      : (Op[1] ? ZERO_C : MIN_C);

    // The partial remainder is always below the divisor, so bit XLEN of the trial difference is the borrow.
    assign trial_s    = {rem_r, quo_r[XLEN-1]} - {1'b0, dvs_r};
    assign q_bit_s    = ~trial_s[XLEN];
    assign rem_next_s = q_bit_s ? trial_s[XLEN-1:0] : {rem_r[XLEN-2:0], quo_r[XLEN-1]};
    assign quo_next_s = {quo_r[XLEN-2:0], q_bit_s};

    assign quo_fix_s     = (dvd_sgn_r ^ dvs_sgn_r) ? (ZERO_C - quo_next_s) : quo_next_s;
    assign rem_fix_s     = dvd_sgn_r ? (ZERO_C - rem_next_s) : rem_next_s;
    assign calc_result_s = rem_sel_r ? rem_fix_s : quo_fix_s;

    // State register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; Kill overrides everything.
    always_comb begin
        state_s = state_r;
        if (Kill) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        state_s = fast_s ? DONE : CALC;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CALC: begin
                    if (last_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Operand latching, iteration datapath and registered outputs.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            rem_sel_r <= 1'b0;
            dvd_sgn_r <= 1'b0;
            dvs_sgn_r <= 1'b0;
            quo_r     <= ZERO_C;
            dvs_r     <= ZERO_C;
            rem_r     <= ZERO_C;
            result_r  <= ZERO_C;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= (state_s == DONE);
            if (accept_s) begin
                rem_sel_r <= Op[1];
                dvd_sgn_r <= rs1_neg_s;
                dvs_sgn_r <= rs2_neg_s;
                quo_r     <= rs1_mag_s;
                dvs_r     <= rs2_mag_s;
                rem_r     <= ZERO_C;
                cnt_r     <= {CW{1'b0}};
                if (fast_s) begin
                    result_r <= fast_result_s;
                end
            end else if ((state_r == CALC) && !Kill) begin
                quo_r <= quo_next_s;
                rem_r <= rem_next_s;
                cnt_r <= cnt_r + CW'(1);
                if (last_s) begin
                    result_r <= calc_result_s;
                end
            end
        end
    end

    assign Busy   = busy_r;
    assign Done   = done_r;
    assign Result = result_r;

endmodule
